// File: rtl/dht11_pkg.sv
// Shared DHT11 definitions: FSM state codes, protocol timing constants and the
// frame checksum helper, used by both the emulator and the reader.
package dht11_pkg;

  localparam int US_W = 15;
  typedef logic [US_W-1:0] us_t;

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] HOST_LOW  = 4'd1;
  localparam logic [3:0] RESP_DLY  = 4'd2;
  localparam logic [3:0] RESP_LOW  = 4'd3;
  localparam logic [3:0] RESP_HIGH = 4'd4;
  localparam logic [3:0] BIT_LOW   = 4'd5;
  localparam logic [3:0] BIT_HIGH  = 4'd6;
  localparam logic [3:0] END_LOW   = 4'd7;
  localparam logic [3:0] WAIT_HIGH = 4'd8;

  localparam int RESP_LOW_US  = 80;
  localparam int RESP_HIGH_US = 80;
  localparam int BIT_LOW_US   = 50;
  localparam int END_LOW_US   = 50;
  localparam int FRAME_BITS   = 40;

  function automatic logic [7:0] dht11_checksum(input logic [7:0] a, input logic [7:0] b,
                                                input logic [7:0] c, input logic [7:0] d);
    logic [9:0] sum;
    sum = 10'(a) + 10'(b) + 10'(c) + 10'(d);
    return sum[7:0];
  endfunction

endpackage

// File: rtl/dht11_us_timer.sv
// Microsecond time base: prescaler emitting a tick every US_DIV cycles and a
// saturating microsecond counter; both restart on clear_i.
module dht11_us_timer
  import dht11_pkg::*;
#(
  parameter int US_DIV = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  output logic tick_o,
  output us_t  count_o
);

  localparam int PW = (US_DIV > 1) ? $clog2(US_DIV) : 1;

  logic [PW-1:0] presc_q;
  us_t           count_q;

  assign tick_o  = (presc_q == PW'(US_DIV - 1));
  assign count_o = count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
      count_q <= '0;
    end else if (clear_i) begin
      presc_q <= '0;
      count_q <= '0;
    end else begin
      presc_q <= tick_o ? '0 : presc_q + PW'(1);
      // Saturate so a stuck-low line can never wrap into a false short start.
      if (tick_o && (count_q != '1)) count_q <= count_q + us_t'(1);
    end
  end

endmodule

// File: rtl/dht11_emulator.sv
// DHT11 sensor emulator: detects the host start pulse, answers with the presence
// response and shifts out the 40-bit humidity/temperature/checksum frame.
module dht11_emulator
  import dht11_pkg::*;
#(
  parameter int US_DIV       = 50,
  parameter int START_MIN_US = 18000,
  parameter int RESP_DLY_US  = 30,
  parameter int BIT1_HIGH_US = 70,
  parameter int BIT0_HIGH_US = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dht_in,
  output logic       dht_oe,
  input  logic [7:0] hum_int,
  input  logic [7:0] hum_dec,
  input  logic [7:0] temp_int,
  input  logic [7:0] temp_dec,
  output logic       busy,
  output logic       done,
  output logic       short_start,
  output logic [3:0] state_dbg
);

  logic [1:0]            sync_q;
  logic                  line_s;
  logic [3:0]            state_q, state_d;
  logic [FRAME_BITS-1:0] sr_q, sr_d;
  logic [5:0]            bit_cnt_q, bit_cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  short_q, short_d;
  logic                  oe_q, oe_d;
  logic                  us_tick;
  us_t                   us_cnt;
  us_t                   dur_m1;
  logic                  expired;

  assign line_s      = sync_q[1];
  assign dht_oe      = oe_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign short_start = short_q;
  assign state_dbg   = state_q;

  dht11_us_timer #(.US_DIV(US_DIV)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear_i (state_d != state_q),
    .tick_o  (us_tick),
    .count_o (us_cnt)
  );

  // The timer restarts on every state entry, so a state of N us ends on the
  // tick that closes microsecond N-1.
  always_comb begin
    dur_m1 = '0;
    case (state_q)
      RESP_DLY:  dur_m1 = us_t'(RESP_DLY_US - 1);
      RESP_LOW:  dur_m1 = us_t'(RESP_LOW_US - 1);
      RESP_HIGH: dur_m1 = us_t'(RESP_HIGH_US - 1);
      BIT_LOW:   dur_m1 = us_t'(BIT_LOW_US - 1);
      BIT_HIGH:  dur_m1 = sr_q[FRAME_BITS-1] ? us_t'(BIT1_HIGH_US - 1) : us_t'(BIT0_HIGH_US - 1);
      END_LOW:   dur_m1 = us_t'(END_LOW_US - 1);
      default:   dur_m1 = '0;
    endcase
  end

  assign expired = us_tick && (us_cnt == dur_m1);

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    short_d   = 1'b0;
    case (state_q)
      IDLE:      if (!line_s) state_d = HOST_LOW;
      HOST_LOW: begin
        if (line_s) begin
          if (us_cnt >= us_t'(START_MIN_US)) begin
            sr_d      = {hum_int, hum_dec, temp_int, temp_dec,
                         dht11_checksum(hum_int, hum_dec, temp_int, temp_dec)};
            bit_cnt_d = '0;
            busy_d    = 1'b1;
            state_d   = RESP_DLY;
          end else begin
            short_d = 1'b1;
            state_d = IDLE;
          end
        end
      end
      RESP_DLY:  if (expired) state_d = RESP_LOW;
      RESP_LOW:  if (expired) state_d = RESP_HIGH;
      RESP_HIGH: if (expired) state_d = BIT_LOW;
      BIT_LOW:   if (expired) state_d = BIT_HIGH;
      BIT_HIGH: begin
        if (expired) begin
          sr_d      = {sr_q[FRAME_BITS-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 6'd1;
          state_d   = (bit_cnt_q == 6'(FRAME_BITS - 1)) ? END_LOW : BIT_LOW;
        end
      end
      END_LOW:   if (expired) state_d = WAIT_HIGH;
      // Our own end-low is still in the synchronizer; wait for it to clear.
      WAIT_HIGH: begin
        if (line_s) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default:   state_d = IDLE;
    endcase
  end

  assign oe_d = (state_d == RESP_LOW) || (state_d == BIT_LOW) || (state_d == END_LOW);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q    <= 2'b11;
      state_q   <= IDLE;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      short_q   <= 1'b0;
      oe_q      <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], dht_in};
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      short_q   <= short_d;
      oe_q      <= oe_d;
    end
  end

endmodule

// File: tb/tb_dht11_emulator.sv
// Bench for dht11_emulator: acts as the host reader on an open-drain line,
// decodes the emulator's waveform and compares it with a byte-level model.
module tb_dht11_emulator;

  localparam int US_DIV       = 2;
  localparam int START_MIN_US = 200;
  localparam int RESP_DLY_US  = 30;
  localparam int BIT1_HIGH_US = 70;
  localparam int BIT0_HIGH_US = 27;
  localparam int RESP_US      = 80;
  localparam int BITLOW_US    = 50;
  localparam int ENDLOW_US    = 50;
  localparam int EV_NONE = 0, EV_CHANGE = 1, EV_RESET = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       host_pull = 1'b0;
  logic [7:0] hum_int = '0, hum_dec = '0, temp_int = '0, temp_dec = '0;
  logic       dht_oe, busy, done, short_start;
  logic [3:0] state_dbg;
  wire        dht_in = ~(host_pull | dht_oe);

  int checks = 0, errors = 0;
  int done_cnt = 0, short_cnt = 0, both_cnt = 0, oe_cnt = 0, busy_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_byte;

  dht11_emulator #(
    .US_DIV(US_DIV), .START_MIN_US(START_MIN_US), .RESP_DLY_US(RESP_DLY_US),
    .BIT1_HIGH_US(BIT1_HIGH_US), .BIT0_HIGH_US(BIT0_HIGH_US)
  ) dut (
    .clk(clk), .rst(rst), .dht_in(dht_in), .dht_oe(dht_oe),
    .hum_int(hum_int), .hum_dec(hum_dec), .temp_int(temp_int), .temp_dec(temp_dec),
    .busy(busy), .done(done), .short_start(short_start), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst) begin
      if (done) done_cnt++;
      if (short_start) short_cnt++;
      if (done && short_start) both_cnt++;
      if (dht_oe) oe_cnt++;
      if (busy) busy_cnt++;
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic host_start(input int low_us);
    @(posedge clk);
    #1 host_pull = 1'b1;
    repeat (low_us * US_DIV) @(posedge clk);
    #1 host_pull = 1'b0;
  endtask

  // Count consecutive negedge samples of dht_oe at lvl; returns on the first
  // differing sample, which belongs to the next phase.
  task automatic measure(input logic lvl, input int first, output int n);
    n = first;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      if (dht_oe !== lvl) return;
      n++;
    end
  endtask

  task automatic run_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input logic [7:0] b3, input int low_us, input int ev_kind,
                           input int ev_bit, input logic [7:0] ev_val);
    int n, bad_low, bad_high, d0, nom, sum;
    logic [7:0] eb[5];
    logic [7:0] got;
    logic ref_bit;
    hum_int = b0; hum_dec = b1; temp_int = b2; temp_dec = b3;
    sum = int'(b0) + int'(b1) + int'(b2) + int'(b3);
    eb[0] = b0; eb[1] = b1; eb[2] = b2; eb[3] = b3; eb[4] = 8'(sum % 256);
    for (int j = 0; j < 5; j++) exp_q.push_back(eb[j]);
    d0 = done_cnt;
    host_start(low_us);
    measure(1'b0, 0, n);
    check("resp_delay_window", (n >= RESP_DLY_US * US_DIV + 2) && (n <= RESP_DLY_US * US_DIV + 4), 1);
    check("busy_in_frame", busy, 1);
    measure(1'b1, 1, n);
    check("resp_low", n, RESP_US * US_DIV);
    measure(1'b0, 1, n);
    check("resp_high", n, RESP_US * US_DIV);
    bad_low = 0; bad_high = 0; got = '0;
    for (int i = 0; i < 40; i++) begin
      if (ev_kind == EV_RESET && i == ev_bit) begin
        repeat (10) @(negedge clk);
        #3 rst = 1'b0;
        #1 check("oe_at_reset", dht_oe, 0);
        check("busy_at_reset", busy, 0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        repeat (20) @(negedge clk);
        check("no_done_after_abort", done_cnt - d0, 0);
        return;
      end
      measure(1'b1, 1, n);
      if (n != BITLOW_US * US_DIV) bad_low++;
      measure(1'b0, 1, n);
      ref_bit = eb[i/8][7-(i%8)];
      nom = ref_bit ? BIT1_HIGH_US * US_DIV : BIT0_HIGH_US * US_DIV;
      if (n < nom - 1 || n > nom + 1) bad_high++;
      got = {got[6:0], (n > (BIT1_HIGH_US + BIT0_HIGH_US) * US_DIV / 2)};
      if (i % 8 == 7) begin
        last_byte = got;
        check($sformatf("byte%0d", i / 8), got, exp_q.pop_front());
      end
      if (ev_kind == EV_CHANGE && i == ev_bit) hum_int = ev_val;
    end
    check("bit_low_bad", bad_low, 0);
    check("bit_high_bad", bad_high, 0);
    measure(1'b1, 1, n);
    check("end_low", n, ENDLOW_US * US_DIV);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done_cnt != d0) break;
    end
    repeat (5) @(negedge clk);
    check("done_pulses", done_cnt - d0, 1);
    check("busy_after_frame", busy, 0);
  endtask

  initial begin
    int o0, b0, s0, d0;
    // Reset held low, line high.
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_oe", dht_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_short", short_start, 0);
    rst = 1'b1;
    o0 = oe_cnt; b0 = busy_cnt; s0 = short_cnt; d0 = done_cnt;
    repeat (1000 * US_DIV) @(negedge clk);
    check("idle_oe", oe_cnt - o0, 0);
    check("idle_busy", busy_cnt - b0, 0);
    check("idle_short", short_cnt - s0, 0);
    check("idle_done", done_cnt - d0, 0);

    // Nominal frame: 45.0 %RH, 23.1 C.
    run_frame(8'd45, 8'd0, 8'd23, 8'd1, START_MIN_US + 10, EV_NONE, 0, 8'd0);

    // Host pulse just too short.
    o0 = oe_cnt; b0 = busy_cnt; s0 = short_cnt;
    host_start(START_MIN_US - 1);
    repeat (20) @(negedge clk);
    check("short_pulse", short_cnt - s0, 1);
    check("short_oe", oe_cnt - o0, 0);
    check("short_busy", busy_cnt - b0, 0);

    // Checksum wraps: 360 mod 256.
    run_frame(8'd200, 8'd100, 8'd50, 8'd10, START_MIN_US + 10, EV_NONE, 0, 8'd0);
    check("chk_byte_0x68", last_byte, 8'h68);

    // Input change mid-frame must not affect the frame in flight.
    run_frame(8'd45, 8'd0, 8'd23, 8'd1, START_MIN_US + 10, EV_CHANGE, 5, 8'd99);
    run_frame(8'd99, 8'd0, 8'd23, 8'd1, START_MIN_US + 10, EV_NONE, 0, 8'd0);

    // Reset mid-frame, then a fresh full frame.
    run_frame(8'd12, 8'd34, 8'd56, 8'd78, START_MIN_US + 10, EV_RESET, 12, 8'd0);
    run_frame(8'd12, 8'd34, 8'd56, 8'd78, START_MIN_US + 10, EV_NONE, 0, 8'd0);

    // Random data; first uses the shortest accepted start.
    run_frame(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
              8'($urandom_range(0, 255)), START_MIN_US + 1, EV_NONE, 0, 8'd0);
    run_frame(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
              8'($urandom_range(0, 255)), START_MIN_US + int'($urandom_range(2, 30)), EV_NONE, 0, 8'd0);

    check("done_short_overlap", both_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
